// File: rtl/shift_fifo_pkg.sv
// Shared opcode encodings and width helpers for the buffered shift FIFO.
// Purely declarative: no logic, no latency, no flow control.
package shift_fifo_pkg;

    localparam logic [1:0] OP_PASS = 2'b00;
    localparam logic [1:0] OP_SLL  = 2'b01;
    localparam logic [1:0] OP_SRL  = 2'b10;
    localparam logic [1:0] OP_SRA  = 2'b11;

    // Pointer/occupancy width: one extra bit so DEPTH itself is representable.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/shift_fifo_shift_unit.sv
// Combinational barrel shift of one word by its own opcode/amount; zero latency.
// No flow control; amounts >= WIDTH saturate to zero or sign fill.
module shift_unit
    import shift_fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int AW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic [1:0]       i_op,
    input  logic [AW-1:0]    i_amt,
    output logic [WIDTH-1:0] o_result
);

    logic [WIDTH-1:0] w_res;

    always_comb begin
        w_res = i_data;
        case (i_op)
            OP_PASS: w_res = i_data;
            OP_SLL:  w_res = i_data << i_amt;
            OP_SRL:  w_res = i_data >> i_amt;
            OP_SRA:  w_res = $signed(i_data) >>> i_amt;
            default: w_res = i_data;
        endcase
    end

    assign o_result = w_res;

endmodule

// File: rtl/shift_fifo.sv
// FIFO of shift commands with first-word fall-through; head is shifted combinationally on the way out.
// in_ready drops when full (no same-cycle pop credit); out_valid drops when empty (no bypass).
module shift_fifo
    import shift_fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(WIDTH),
    localparam int CW   = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_op,
    input  logic [AW-1:0]    in_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count,
    output logic             overflow
);

    typedef struct packed {
        logic [1:0]       op;
        logic [AW-1:0]    amt;
        logic [WIDTH-1:0] data;
    } entry_t;

    entry_t           r_mem [DEPTH];
    logic [CW-1:0]    r_wptr;
    logic [CW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             r_overflow;

    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    entry_t           w_head;
    logic [WIDTH-1:0] w_shifted;

    // Extra MSB on each pointer distinguishes full from empty when low bits match.
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[CW-2:0] == r_rptr[CW-2:0]) && (r_wptr[CW-1] != r_rptr[CW-1]);
    assign w_push  = in_valid && !w_full;
    assign w_pop   = out_ready && !w_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[CW-2:0]] <= '{op: in_op, amt: in_amt, data: in_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + CW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + CW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
            if (in_valid && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign w_head = r_mem[r_rptr[CW-2:0]];

    shift_unit #(
        .WIDTH (WIDTH)
    ) u_shift (
        .i_data   (w_head.data),
        .i_op     (w_head.op),
        .i_amt    (w_head.amt),
        .o_result (w_shifted)
    );

    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign out_data  = w_empty ? '0 : w_shifted;
    assign count     = r_count;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_shift_fifo.sv
// Directed bench for shift_fifo (WIDTH=8, DEPTH=32): reset, opcodes, full/overflow, wrap, mid-run reset.
module tb_shift_fifo;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [1:0] in_op;
    logic [2:0] in_amt;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [5:0] count;
    logic       overflow;

    int total;
    int bad;

    shift_fifo #(
        .WIDTH (8),
        .DEPTH (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_op     (in_op),
        .in_amt    (in_amt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_data = 8'h00; in_op = 2'b00; in_amt = 3'd0;
        tick(); tick();
        rst = 1'b0;
        total++; if (count !== 6'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data: got %h want 00", out_data); end
    endtask

    task automatic test_single_sra();
        in_valid = 1'b1; in_data = 8'hB4; in_op = 2'b11; in_amt = 3'd2;
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid: got %b want 1", out_valid); end
        total++; if (out_data !== 8'hED) begin bad++; $display("FAIL single_data: got %h want ed", out_data); end
        total++; if (count !== 6'd1) begin bad++; $display("FAIL single_count: got %0d want 1", count); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++; if (count !== 6'd0) begin bad++; $display("FAIL single_pop_count: got %0d want 0", count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_pop_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_opcodes();
        logic [7:0] exp [4];
        exp[0] = 8'h81; exp[1] = 8'h02; exp[2] = 8'h40; exp[3] = 8'hC0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 8'h81; in_op = 2'(i); in_amt = 3'd1;
            tick();
        end
        in_valid = 1'b0;
        total++; if (count !== 6'd4) begin bad++; $display("FAIL ops_count: got %0d want 4", count); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++; if (out_data !== exp[i]) begin bad++; $display("FAIL ops_data[%0d]: got %h want %h", i, out_data, exp[i]); end
            tick();
        end
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ops_drained: got %b want 0", out_valid); end
    endtask

    task automatic test_full_overflow();
        out_ready = 1'b0;
        for (int i = 0; i < 32; i++) begin
            in_valid = 1'b1; in_data = 8'(i); in_op = 2'b00; in_amt = 3'd0;
            tick();
        end
        in_valid = 1'b0;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
        total++; if (count !== 6'd32) begin bad++; $display("FAIL full_count: got %0d want 32", count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL full_no_ovf_yet: got %b want 0", overflow); end
        in_valid = 1'b1; in_data = 8'hEE;
        tick();
        in_valid = 1'b0;
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", overflow); end
        total++; if (count !== 6'd32) begin bad++; $display("FAIL ovf_count: got %0d want 32", count); end
    endtask

    task automatic test_full_push_pop();
        in_valid = 1'b1; in_data = 8'h77; in_op = 2'b00; out_ready = 1'b1;
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL fpp_head: got %h want 00", out_data); end
        tick();
        total++; if (count !== 6'd31) begin bad++; $display("FAIL fpp_pop_only: got %0d want 31", count); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fpp_ready_back: got %b want 1", in_ready); end
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        total++; if (count !== 6'd32) begin bad++; $display("FAIL fpp_push_after: got %0d want 32", count); end
        out_ready = 1'b1;
        for (int i = 1; i < 33; i++) begin
            logic [7:0] e;
            e = (i == 32) ? 8'h77 : 8'(i);
            total++; if (out_data !== e) begin bad++; $display("FAIL fpp_drain[%0d]: got %h want %h", i, out_data, e); end
            tick();
        end
        out_ready = 1'b0;
        total++; if (count !== 6'd0) begin bad++; $display("FAIL fpp_drained: got %0d want 0", count); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_data = 8'(i); in_op = 2'b00; in_amt = 3'd0;
            tick();
        end
        total++; if (count !== 6'd16) begin bad++; $display("FAIL b2b_half: got %0d want 16", count); end
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_data = 8'(i + 16);
            total++; if (out_data !== 8'(i)) begin bad++; $display("FAIL b2b_data[%0d]: got %h want %h", i, out_data, 8'(i)); end
            tick();
            total++; if (count !== 6'd16) begin bad++; $display("FAIL b2b_count[%0d]: got %0d want 16", i, count); end
        end
        in_valid = 1'b0;
        // Pop 6 of the remaining 16 so exactly 10 are queued for the reset test.
        for (int i = 0; i < 6; i++) begin
            tick();
        end
        out_ready = 1'b0;
        total++; if (count !== 6'd10) begin bad++; $display("FAIL b2b_ten: got %0d want 10", count); end
        total++; if (out_data !== 8'd106) begin bad++; $display("FAIL b2b_head: got %h want 6a", out_data); end
    endtask

    task automatic test_mid_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (count !== 6'd0) begin bad++; $display("FAIL mrst_count: got %0d want 0", count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mrst_valid: got %b want 0", out_valid); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL mrst_overflow: got %b want 0", overflow); end
        in_valid = 1'b1; in_data = 8'h5A; in_op = 2'b00; in_amt = 3'd3;
        tick();
        in_valid = 1'b0;
        total++; if (out_data !== 8'h5A) begin bad++; $display("FAIL mrst_first: got %h want 5a", out_data); end
        total++; if (count !== 6'd1) begin bad++; $display("FAIL mrst_one: got %0d want 1", count); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single_sra();
        test_opcodes();
        test_full_overflow();
        test_full_push_pop();
        test_back_to_back();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_fifo.md
Name: shift_fifo

Overview:
- Parametrised buffered shift unit: a synchronous FIFO of WIDTH-bit words, where each entry carries its own shift opcode and amount.
- Words are shifted on the read side (pass, <<, >>, >>>) as they leave the FIFO.
- Generalises the fixed 9-bit, single-shot shift datapath to configurable width and depth, adds a valid/ready handshake on both sides, and adds occupancy/overflow status.
- Sits between a producer issuing shift commands and a consumer with variable backpressure.

Parameters:
- WIDTH, 8: data word width in bits (>= 2).
- DEPTH, 32: FIFO entries; must be a power of two (>= 2).
- AW, $clog2(WIDTH): shift-amount width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  producer has a command.
- in_ready  out  1  FIFO can accept.
- in_data  in  WIDTH  operand.
- in_op  in  2  shift opcode (see package).
- in_amt  in  AW  shift amount.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer accepts.
- out_data  out  WIDTH  shifted head operand.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: push attempted while full.

Behaviour:
- One clock, clk; reset rst is synchronous and active-high.
- Reset (rst high at a rising edge):
  - Pointers and count go to 0; overflow = 0; in_ready = 1; out_valid = 0.
  - out_data is don't-care while out_valid = 0; the implementation drives 0 when empty.
  - Storage contents are not cleared.
- Storage: array of DEPTH entries {op[1:0], amt[AW-1:0], data[WIDTH-1:0]}.
- Pointers: write and read pointers are $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit.
  - empty = pointers equal.
  - full = low bits equal and MSBs differ.
- push = in_valid & in_ready, where in_ready = !full.
- pop = out_valid & out_ready, where out_valid = !empty.
- Latency: first-word fall-through.
  - A word pushed at edge N is presented on out_data with out_valid = 1 from cycle N+1 onward.
  - There is no read-side register; out_data is combinational from the head entry via the shift unit.
- Opcodes:
  - 00 PASS: data.
  - 01 SLL: data << amt, zero fill.
  - 10 SRL: data >> amt, zero fill.
  - 11 SRA: signed data >>> amt, fill with data[WIDTH-1].
  - Result is truncated to WIDTH bits.
  - If amt >= WIDTH (non-power-of-two WIDTH only): SLL/SRL give 0; SRA gives all bits equal to data[WIDTH-1].
- count update: +1 on push only, -1 on pop only, unchanged on push & pop together.
- Simultaneous push and pop when neither full nor empty: both take effect; count unchanged.
- When full: in_ready = 0.
  - A push is not accepted even if a pop occurs in the same cycle.
  - in_ready returns to 1 in the cycle after the pop.
- When empty: out_valid = 0; out_ready is ignored. A same-cycle push is not bypassed to the output.
- overflow: set at the edge when in_valid = 1 and full = 1. Cleared only by rst.
- Wrap-around: pointers increment modulo 2*DEPTH; ordering is preserved across any number of wraps.
- in_op, in_amt, in_data are sampled only on push. The head entry is stable until popped.
- Reset mid-operation: all queued entries are discarded. The first push after rst deasserts is the next word out.
- No X propagation: outputs are defined from the first edge with rst high.

Decomposition:
- Package shift_fifo_pkg:
  - Opcode localparams OP_PASS = 2'b00, OP_SLL = 2'b01, OP_SRL = 2'b10, OP_SRA = 2'b11.
  - Function for the count width.
- Sub-module shift_unit (combinational, parameter WIDTH):
  - Inputs: data, op, amt. Output: result.
  - Implements the case on op with <<, >>, >>>.
  - Instantiated once on the head entry.
- FIFO control (pointers, count, flags) lives in shift_fifo.

Test Plan:
- Reset, then push 8'hB4 with op SRA, amt 2 -> next cycle out_valid = 1, out_data = 8'hED, count = 1. Pop -> count = 0, out_valid = 0.
- Push 8'h81 four times with ops PASS/SLL/SRL/SRA, amt 1 -> pops in order yield 8'h81, 8'h02, 8'h40, 8'hC0.
- Hold out_ready = 0 and push 32 words -> in_ready = 0, count = 32. Drive in_valid one more cycle -> overflow = 1, count stays 32. Overflow stays 1 after draining.
- Full FIFO with in_valid = 1 and out_ready = 1 together -> that cycle pops only (count 31). Next cycle the push is accepted (count 32).
- Half full (16 entries), then 100 cycles of continuous push & pop with an incrementing data pattern -> count constant at 16, output order matches input through multiple pointer wraps.
- Assert rst for one cycle with 10 entries queued -> count = 0, out_valid = 0, overflow = 0. Push 8'h5A PASS -> out_data = 8'h5A next cycle.
